// File: rtl/wb_completion_arbiter.sv
// Merges result completions from N functional units into the single register-file write-back port.
// Define WB_BYPASS_EN to let a result skip the FIFOs when every FIFO is empty (1-cycle latency).
module wb_completion_arbiter #(
    parameter int N_UNITS    = 4,
    parameter int FIFO_DEPTH = 2,
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_UNITS-1:0]          src_valid,
    output logic [N_UNITS-1:0]          src_ready,
    input  logic [N_UNITS*REG_AW-1:0]   src_rd,
    input  logic [N_UNITS*XLEN-1:0]     src_data,
    input  logic [N_UNITS-1:0]          src_is_fp,
    output logic                        wb_valid,
    output logic                        wb_is_fp,
    output logic [REG_AW-1:0]           wb_rd,
    output logic [XLEN-1:0]             wb_data,
    output logic [$clog2(N_UNITS)-1:0]  wb_src,
    output logic                        wb_pending
);

    localparam int SW = $clog2(N_UNITS);
    localparam int PW = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]       wr_ptr [N_UNITS];
    logic [PW:0]       rd_ptr [N_UNITS];
    logic [REG_AW-1:0] q_rd   [N_UNITS][FIFO_DEPTH];
    logic [XLEN-1:0]   q_data [N_UNITS][FIFO_DEPTH];
    logic              q_fp   [N_UNITS][FIFO_DEPTH];

    logic [N_UNITS-1:0] full, empty, req, push, pop, byp_take;
    logic               byp_mode;
    logic               gnt_any;
    logic [SW-1:0]      gnt_idx;
    logic [SW-1:0]      rr_ptr;
    logic [REG_AW-1:0]  sel_rd;
    logic [XLEN-1:0]    sel_data;
    logic               sel_fp;

    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N_UNITS) s = s - N_UNITS;
        return SW'(s);
    endfunction

    always_comb begin
        full  = '0;
        empty = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][PW] != rd_ptr[i][PW]) &&
                       (wr_ptr[i][PW-1:0] == rd_ptr[i][PW-1:0]);
        end
    end

    assign src_ready  = ~full;
    assign wb_pending = |(~empty);

`ifdef WB_BYPASS_EN
    assign byp_mode = &empty;
    assign req      = byp_mode ? src_valid : ~empty;
`else
    assign byp_mode = 1'b0;
    assign req      = ~empty;
`endif

    // Round-robin search starting at rr_ptr.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            if (!gnt_any && req[wrap_add(rr_ptr, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_add(rr_ptr, k);
            end
        end
    end

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        sel_fp   = 1'b0;
        pop      = '0;
        byp_take = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (gnt_any && gnt_idx == SW'(i)) begin
                if (byp_mode) begin
                    sel_rd      = src_rd[i*REG_AW +: REG_AW];
                    sel_data    = src_data[i*XLEN +: XLEN];
                    sel_fp      = src_is_fp[i];
                    byp_take[i] = 1'b1;
                end else begin
                    sel_rd   = q_rd[i][rd_ptr[i][PW-1:0]];
                    sel_data = q_data[i][rd_ptr[i][PW-1:0]];
                    sel_fp   = q_fp[i][rd_ptr[i][PW-1:0]];
                    pop[i]   = 1'b1;
                end
            end
        end
    end

    // A full FIFO refuses even when it pops this cycle: ready comes from registered state only.
    assign push = src_valid & ~full & ~byp_take;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_UNITS; i++) begin
            if (push[i]) begin
                q_rd[i][wr_ptr[i][PW-1:0]]   <= src_rd[i*REG_AW +: REG_AW];
                q_data[i][wr_ptr[i][PW-1:0]] <= src_data[i*XLEN +: XLEN];
                q_fp[i][wr_ptr[i][PW-1:0]]   <= src_is_fp[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_UNITS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            rr_ptr   <= '0;
            wb_valid <= 1'b0;
            wb_is_fp <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_src   <= '0;
        end else begin
            for (int i = 0; i < N_UNITS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + (PW+1)'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + (PW+1)'(1);
            end
            // Integer x0 writes are consumed but never strobe the register file.
            wb_valid <= gnt_any && !(sel_rd == '0 && !sel_fp);
            if (gnt_any) begin
                wb_is_fp <= sel_fp;
                wb_rd    <= sel_rd;
                wb_data  <= sel_data;
                wb_src   <= gnt_idx;
                rr_ptr   <= wrap_add(gnt_idx, 1);
            end
        end
    end

endmodule

// File: tb/tb_wb_completion_arbiter.sv
// Self-checking bench for wb_completion_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the arbiter's write-back behaviour.
module tb_wb_completion_arbiter;

    localparam int N    = 4;
    localparam int D    = 2;
    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int SW   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      src_valid, src_ready, src_is_fp;
    logic [N*AW-1:0]   src_rd;
    logic [N*XLEN-1:0] src_data;
    logic              wb_valid, wb_is_fp, wb_pending;
    logic [AW-1:0]     wb_rd;
    logic [XLEN-1:0]   wb_data;
    logic [SW-1:0]     wb_src;

    always #5 clk = ~clk;

    wb_completion_arbiter #(.N_UNITS(N), .FIFO_DEPTH(D), .XLEN(XLEN), .REG_AW(AW)) dut (
        .clk(clk), .reset(reset),
        .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd),
        .src_data(src_data), .src_is_fp(src_is_fp),
        .wb_valid(wb_valid), .wb_is_fp(wb_is_fp), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_src(wb_src), .wb_pending(wb_pending)
    );

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
        logic            fp;
    } entry_t;

    entry_t mq [N][D];
    int     mn [N];
    int     m_rr;
    logic   m_wv;
    entry_t m_wb;
    int     m_src;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) mn[i] = 0;
        m_rr  = 0;
        m_wv  = 1'b0;
        m_wb  = '0;
        m_src = 0;
    endtask

    // Behaviour at one rising edge, from the queue contents and the inputs presented.
    task automatic model_edge();
        entry_t       in_e [N];
        entry_t       e;
        logic [N-1:0] acc;
        logic         byp;
        int           g, idx;
        if (reset) begin
            model_clear();
        end else begin
            for (int i = 0; i < N; i++) begin
                in_e[i].rd   = src_rd[i*AW +: AW];
                in_e[i].data = src_data[i*XLEN +: XLEN];
                in_e[i].fp   = src_is_fp[i];
                acc[i] = src_valid[i] && (mn[i] < D);
            end
            byp = 1'b0;
`ifdef WB_BYPASS_EN
            byp = 1'b1;
            for (int i = 0; i < N; i++) if (mn[i] != 0) byp = 1'b0;
`endif
            g = -1;
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (g < 0 && (byp ? src_valid[idx] : (mn[idx] > 0))) g = idx;
            end
            m_wv = 1'b0;
            if (g >= 0) begin
                if (byp) begin
                    e = in_e[g];
                    acc[g] = 1'b0;
                end else begin
                    e = mq[g][0];
                    for (int j = 0; j < D - 1; j++) mq[g][j] = mq[g][j+1];
                    mn[g]--;
                end
                m_wv  = !(e.rd == 0 && !e.fp);
                m_wb  = e;
                m_src = g;
                m_rr  = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    mq[i][mn[i]] = in_e[i];
                    mn[i]++;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_rdy;
        logic         exp_pend;
        exp_pend = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = (mn[i] < D);
            if (mn[i] > 0) exp_pend = 1'b1;
        end
        check_val("src_ready", src_ready, exp_rdy);
        check_val("wb_pending", wb_pending, exp_pend);
        check_val("wb_valid", wb_valid, m_wv);
        if (m_wv) begin
            check_val("wb_rd", wb_rd, m_wb.rd);
            check_val("wb_data", wb_data, m_wb.data);
            check_val("wb_is_fp", wb_is_fp, m_wb.fp);
            check_val("wb_src", wb_src, m_src);
        end
    endtask

    // Called at a falling edge with inputs already set up for the coming rising edge.
    task automatic step();
        check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] d,
                           input logic fp);
        src_valid[i]             = 1'b1;
        src_rd[i*AW +: AW]       = rd;
        src_data[i*XLEN +: XLEN] = d;
        src_is_fp[i]             = fp;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_wb_valid"}, wb_valid, 0);
        check_val({tag, "_wb_rd"}, wb_rd, 0);
        check_val({tag, "_wb_data"}, wb_data, 0);
        check_val({tag, "_wb_is_fp"}, wb_is_fp, 0);
        check_val({tag, "_wb_src"}, wb_src, 0);
        check_val({tag, "_wb_pending"}, wb_pending, 0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        src_valid = '0;
        step();
        check_reset_vals("rst");
        reset = 1'b0;
    endtask

    initial begin
        int           got[$];
        logic [31:0]  mul_out[$];
        int           mul_sent, mul_start, cnt;
        bit           bp_seen, accept;

        reset = 1'b1; src_valid = '0; src_rd = '0; src_data = '0; src_is_fp = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("init");
        reset = 1'b0;

        // Idle after reset
        repeat (10) step();
        check_val("idle_ready", src_ready, 4'b1111);
        check_val("idle_valid", wb_valid, 0);

        // Single ALU push
        set_src(0, 5, 32'hDEADBEEF, 1'b0);
        step();
        src_valid = '0;
`ifndef WB_BYPASS_EN
        check_val("lat_cyc1_valid", wb_valid, 0);
        step();
`endif
        check_val("lat_valid", wb_valid, 1);
        check_val("lat_rd", wb_rd, 5);
        check_val("lat_data", wb_data, 32'hDEADBEEF);
        check_val("lat_src", wb_src, 0);
        check_val("lat_fp", wb_is_fp, 0);
        repeat (3) step();

        // All four units in one cycle
        do_reset();
        for (int i = 0; i < N; i++) set_src(i, AW'(i + 1), 32'h1000 + i, 1'b0);
        step();
        src_valid = '0;
        for (int c = 0; c < 6; c++) begin
            if (wb_valid) got.push_back(int'(wb_src));
            step();
        end
        check_val("all4_count", got.size(), 4);
        for (int k = 0; k < got.size() && k < 4; k++) check_val("all4_order", got[k], k);

        // MUL back-pressure while the other units keep the port busy
        do_reset();
        mul_sent = 0; bp_seen = 1'b0;
`ifdef WB_BYPASS_EN
        mul_start = 1;
`else
        mul_start = 0;
`endif
        for (int c = 0; c < 24; c++) begin
            src_valid = '0;
            if (c < 12) begin
                set_src(0, 10, $urandom, 1'b0);
                set_src(2, 12, $urandom, 1'b0);
                set_src(3, 13, $urandom, 1'b1);
                if (c >= mul_start && mul_sent < 3)
                    set_src(1, AW'(20 + mul_sent), 32'h100 + mul_sent, 1'b0);
            end
            if (src_valid[1] && !src_ready[1]) bp_seen = 1'b1;
            if (wb_valid && wb_src == 1) mul_out.push_back(wb_data);
            accept = src_valid[1] && src_ready[1];
            step();
            if (accept) mul_sent++;
        end
        check_val("bp_seen", bp_seen, 1);
        check_val("mul_sent", mul_sent, 3);
        check_val("mul_out_count", mul_out.size(), 3);
        for (int k = 0; k < mul_out.size() && k < 3; k++) check_val("mul_order", mul_out[k], 32'h100 + k);

        // x0 integer write is consumed silently; FP f0 is written
        do_reset();
        set_src(0, 0, 32'hAAAA5555, 1'b0);
        step();
        src_valid = '0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (wb_valid) cnt++;
            step();
        end
        check_val("x0_no_wb", cnt, 0);
        check_val("x0_drained", wb_pending, 0);
        set_src(3, 0, 32'h3F800000, 1'b1);
        step();
        src_valid = '0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (wb_valid) begin
                cnt++;
                check_val("f0_rd", wb_rd, 0);
                check_val("f0_fp", wb_is_fp, 1);
            end
            step();
        end
        check_val("f0_wb_count", cnt, 1);

        // Reset with results buffered
        for (int i = 0; i < 3; i++) set_src(i, AW'(7 + i), 32'h700 + i, 1'b0);
        step();
        src_valid = '0;
        do_reset();
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            if (wb_valid) cnt++;
            step();
        end
        check_val("rst_mid_no_wb", cnt, 0);
        check_val("rst_mid_pending", wb_pending, 0);
        check_val("rst_mid_ready", src_ready, 4'b1111);

        // Random traffic with occasional reset
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                src_valid = '0;
                for (int i = 0; i < N; i++)
                    if ($urandom_range(0, 99) < 45)
                        set_src(i, AW'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
                step();
            end
        end
        src_valid = '0;
        repeat (12) step();
        check_val("final_pending", wb_pending, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
